dmem_handshake: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Adds a valid/ready request channel, a configurable response latency (1..4 cycles), a configurable depth, and error reporting for misaligned, illegal-mode and out-of-range accesses.
- Sits between the datapath load/store path and the word-organised storage, so that multi-cycle control logic can stall on it.
- Supports the RV32I load/store widths selected by funct3.

---
 rtl/dmem_handshake_if.sv | 29 ++
 rtl/dmem_handshake.sv | 177 +++++++++++++++++
 tb/tb_dmem_handshake.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_handshake_if.sv
// Request/response bundle between the load/store datapath and the data memory.
// Latency: none (wires only).
// Backpressure: master holds its req_* fields while req_valid is high and req_ready is low.
// Ports: req_valid/req_ready/req_we/req_mode/req_addr/req_wdata (request channel),
//        rsp_valid/rsp_rdata/rsp_err (one-cycle response strobe), busy (request in flight).
interface dmem_handshake_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_mode, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_mode, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_handshake.sv
// Word-organised data memory with a valid/ready request channel and RV32I load/store widths.
// Latency: rsp_valid pulses LATENCY cycles after the accepting edge; one request per LATENCY+1 cycles.
// Backpressure: req_ready only in IDLE; req_valid while not ready is ignored, requester holds fields.
// Ports: clk, reset (async active-low), bus (dmem_handshake_if.slave: request channel,
//        response strobe with rdata/err, busy).
module dmem_handshake #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  dmem_handshake_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Storage has no reset: contents survive a reset pulse.
  logic [31:0]       mem [DEPTH];

  // Operation under commit. With LATENCY=1 the commit edge is the accept edge, so the
  // live request fields are used; otherwise the fields latched at accept.
  logic              op_we;
  logic [2:0]        op_mode;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [ADDR_W-3:0] op_word_hi;
  logic [IDX_W-1:0]  op_idx;
  logic [31:0]       op_word;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              op_bad;
  logic              op_err;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              commit;
  logic              mem_we;

  always_comb begin
    op_we    = we_q;
    op_mode  = mode_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      op_we    = bus.req_we;
      op_mode  = bus.req_mode;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end
  end

  assign op_idx  = op_addr[IDX_W+1:2];
  assign op_word = mem[op_idx];
  assign lane_b  = op_word[{op_addr[1:0], 3'b000} +: 8];
  assign lane_h  = op_addr[1] ? op_word[31:16] : op_word[15:0];

  // Error decode: illegal funct3, unsigned stores, misalignment, word index past DEPTH.
  always_comb begin
    op_word_hi = op_addr[ADDR_W-1:2] >> IDX_W;
    case (op_mode)
      3'b000:  op_bad = 1'b0;
      3'b001:  op_bad = op_addr[0];
      3'b010:  op_bad = |op_addr[1:0];
      3'b100:  op_bad = op_we;
      3'b101:  op_bad = op_we | op_addr[0];
      default: op_bad = 1'b1;
    endcase
    op_err = op_bad | (op_word_hi != '0);
  end

  always_comb begin
    case (op_mode)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_val = {24'h000000, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_val = {16'h0000, lane_h};
      3'b010:  load_val = op_word;
      default: load_val = 32'h0;
    endcase
  end

  // Store merge keeps untouched lanes of the current word.
  always_comb begin
    merged = op_word;
    case (op_mode[1:0])
      2'b00:   merged[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      2'b01:   merged[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      default: merged = op_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          mode_d  = bus.req_mode;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read and write both happen on the edge that enters RESP.
    commit = (state_d == S_RESP) && (state_q != S_RESP);
    if (commit) begin
      err_d   = op_err;
      rdata_d = (op_err || op_we) ? 32'h0 : load_val;
    end
  end

  // Gated by reset so a request colliding with reset assertion never writes.
  assign mem_we = commit & op_we & ~op_err & reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[op_idx] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mode_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
  assign bus.rsp_err   = (state_q == S_RESP) & err_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_handshake.sv
// Bench for dmem_handshake: three instances at LATENCY 1, 3 and 4 sharing clock and reset.
// Expected responses are queued at accept; a monitor queues observed responses for comparison.
module tb_dmem_handshake;
  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          k;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          k;
    int          cyc;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic        r_valid [3];
  logic        r_we    [3];
  logic [2:0]  r_mode  [3];
  logic [31:0] r_addr  [3];
  logic [31:0] r_wdata [3];
  logic        r_ready [3];
  logic        s_valid [3];
  logic [31:0] s_rdata [3];
  logic        s_err   [3];
  logic        s_busy  [3];

  exp_t exp_q [$];
  obs_t obs_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_handshake_if #(.ADDR_W(32)) if_l1 ();
  dmem_handshake_if #(.ADDR_W(32)) if_l3 ();
  dmem_handshake_if #(.ADDR_W(32)) if_l4 ();

  dmem_handshake #(.DEPTH(DEPTH), .LATENCY(1), .ADDR_W(32)) u_l1 (.clk(clk), .reset(rst_n), .bus(if_l1.slave));
  dmem_handshake #(.DEPTH(DEPTH), .LATENCY(3), .ADDR_W(32)) u_l3 (.clk(clk), .reset(rst_n), .bus(if_l3.slave));
  dmem_handshake #(.DEPTH(DEPTH), .LATENCY(4), .ADDR_W(32)) u_l4 (.clk(clk), .reset(rst_n), .bus(if_l4.slave));

  assign if_l1.req_valid = r_valid[0];
  assign if_l1.req_we    = r_we[0];
  assign if_l1.req_mode  = r_mode[0];
  assign if_l1.req_addr  = r_addr[0];
  assign if_l1.req_wdata = r_wdata[0];
  assign r_ready[0] = if_l1.req_ready;
  assign s_valid[0] = if_l1.rsp_valid;
  assign s_rdata[0] = if_l1.rsp_rdata;
  assign s_err[0]   = if_l1.rsp_err;
  assign s_busy[0]  = if_l1.busy;

  assign if_l3.req_valid = r_valid[1];
  assign if_l3.req_we    = r_we[1];
  assign if_l3.req_mode  = r_mode[1];
  assign if_l3.req_addr  = r_addr[1];
  assign if_l3.req_wdata = r_wdata[1];
  assign r_ready[1] = if_l3.req_ready;
  assign s_valid[1] = if_l3.rsp_valid;
  assign s_rdata[1] = if_l3.rsp_rdata;
  assign s_err[1]   = if_l3.rsp_err;
  assign s_busy[1]  = if_l3.busy;

  assign if_l4.req_valid = r_valid[2];
  assign if_l4.req_we    = r_we[2];
  assign if_l4.req_mode  = r_mode[2];
  assign if_l4.req_addr  = r_addr[2];
  assign if_l4.req_wdata = r_wdata[2];
  assign r_ready[2] = if_l4.req_ready;
  assign s_valid[2] = if_l4.rsp_valid;
  assign s_rdata[2] = if_l4.rsp_rdata;
  assign s_err[2]   = if_l4.rsp_err;
  assign s_busy[2]  = if_l4.busy;

  // Records the edge at which a consumer would sample the strobe (next posedge).
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (s_valid[k]) obs_q.push_back('{s_rdata[k], s_err[k], k, cyc + 1});
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Presents one request, waits for its accepting edge, then drops req_valid.
  task automatic issue(input int k, input logic we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push, input logic exp_err, input logic [31:0] exp_rdata,
                       output int acc);
    int n;
    @(negedge clk);
    r_valid[k] = 1'b1;
    r_we[k]    = we;
    r_mode[k]  = mode;
    r_addr[k]  = addr;
    r_wdata[k] = wdata;
    n = 0;
    while (!r_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    r_valid[k] = 1'b0;
    if (push) exp_q.push_back('{exp_rdata, exp_err, k, acc});
  endtask

  task automatic collect(input int want, output logic got);
    int n;
    n = 0;
    while (obs_q.size() < want && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = (obs_q.size() >= want);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r_valid[k] = 1'b0; r_we[k] = 1'b0; r_mode[k] = 3'b010; r_addr[k] = 32'h0; r_wdata[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({s_valid[k], s_err[k], s_busy[k], s_rdata[k]} !== 35'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: valid=%0b err=%0b busy=%0b rdata=%08h, want all zero",
                 k, s_valid[k], s_err[k], s_busy[k], s_rdata[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (r_ready[k] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_ready[%0d]: req_ready=%0b, want 1", k, r_ready[k]);
      end
    end
  endtask

  task automatic test_word_l1();
    txn_t t [$];
    exp_t e;
    obs_t o;
    logic got;
    int   acc;
    t.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF});
    foreach (t[i]) begin
      issue(0, t[i].we, t[i].mode, t[i].addr, t[i].wdata, 1'b1, t[i].err, t[i].rdata, acc);
      collect(1, got);
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL word_l1[%0d]: no response, want one", i);
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o.k !== e.k || o.err !== e.err || o.rdata !== e.rdata || (o.cyc - e.acc) != lat_of(e.k)) begin
          tests_failed++;
          $display("FAIL word_l1[%0d]: got dut=%0d err=%0b rdata=%08h lat=%0d, want dut=%0d err=%0b rdata=%08h lat=%0d",
                   i, o.k, o.err, o.rdata, o.cyc - e.acc, e.k, e.err, e.rdata, lat_of(e.k));
        end
      end
    end
  endtask

  task automatic test_byte_l3();
    txn_t t [$];
    exp_t e;
    obs_t o;
    logic got;
    int   acc;
    t.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    t.push_back('{1'b1, 3'b000, 32'h13, 32'h77777780, 1'b0, 32'h0});
    t.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80});
    t.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h00000080});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h80ADBEEF});
    t.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFF80AD});
    t.push_back('{1'b0, 3'b101, 32'h10, 32'h0,        1'b0, 32'h0000BEEF});
    foreach (t[i]) begin
      issue(1, t[i].we, t[i].mode, t[i].addr, t[i].wdata, 1'b1, t[i].err, t[i].rdata, acc);
      collect(1, got);
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL byte_l3[%0d]: no response, want one", i);
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o.k !== e.k || o.err !== e.err || o.rdata !== e.rdata || (o.cyc - e.acc) != lat_of(e.k)) begin
          tests_failed++;
          $display("FAIL byte_l3[%0d]: got dut=%0d err=%0b rdata=%08h lat=%0d, want dut=%0d err=%0b rdata=%08h lat=%0d",
                   i, o.k, o.err, o.rdata, o.cyc - e.acc, e.k, e.err, e.rdata, lat_of(e.k));
        end
      end
    end
  endtask

  // req_valid held high: ready drops for WAIT (LATENCY-1 cycles) plus RESP (1 cycle),
  // so accepts are spaced LATENCY+1 apart.
  task automatic test_back_to_back();
    int   n_acc;
    int   last_acc;
    int   low_cnt;
    int   n;
    exp_t e;
    obs_t o;
    n_acc = 0; last_acc = -1; low_cnt = 0;
    @(negedge clk);
    r_valid[1] = 1'b1; r_we[1] = 1'b0; r_mode[1] = 3'b010; r_addr[1] = 32'h10; r_wdata[1] = 32'h0;
    for (int c = 0; c < 14; c++) begin
      if (r_ready[1]) begin
        if (low_cnt > 0) begin
          tests_run++;
          if (low_cnt != 3) begin
            tests_failed++;
            $display("FAIL b2b_ready_low: ran %0d cycles, want 3", low_cnt);
          end
          low_cnt = 0;
        end
        if (last_acc >= 0) begin
          tests_run++;
          if (cyc + 1 - last_acc != 4) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d cycles, want 4", cyc + 1 - last_acc);
          end
        end
        last_acc = cyc + 1;
        n_acc++;
        exp_q.push_back('{32'h80ADBEEF, 1'b0, 1, cyc + 1});
      end else begin
        low_cnt++;
      end
      @(negedge clk);
    end
    r_valid[1] = 1'b0;
    tests_run++;
    if (n_acc != 4) begin
      tests_failed++;
      $display("FAIL b2b_accepts: %0d accepts, want 4", n_acc);
    end
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (obs_q.size() != n_acc) begin
      tests_failed++;
      $display("FAIL b2b_rsp_count: %0d responses, want %0d", obs_q.size(), n_acc);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.k !== e.k || o.err !== e.err || o.rdata !== e.rdata || (o.cyc - e.acc) != 3) begin
        tests_failed++;
        $display("FAIL b2b_rsp: got dut=%0d err=%0b rdata=%08h lat=%0d, want dut=%0d err=%0b rdata=%08h lat=3",
                 o.k, o.err, o.rdata, o.cyc - e.acc, e.k, e.err, e.rdata);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_errors();
    txn_t t [$];
    exp_t e;
    obs_t o;
    logic got;
    int   acc;
    t.push_back('{1'b0, 3'b001, 32'h11,  32'h0,        1'b1, 32'h0});
    t.push_back('{1'b1, 3'b010, 32'h12,  32'h55555555, 1'b1, 32'h0});
    t.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF});
    t.push_back('{1'b0, 3'b111, 32'h10,  32'h0,        1'b1, 32'h0});
    t.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0});
    t.push_back('{1'b1, 3'b100, 32'h10,  32'h000000AA, 1'b1, 32'h0});
    t.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF});
    t.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        1'b1, 32'h0});
    t.push_back('{1'b1, 3'b010, 32'hFC,  32'hCAFEF00D, 1'b0, 32'h0});
    t.push_back('{1'b0, 3'b010, 32'hFC,  32'h0,        1'b0, 32'hCAFEF00D});
    foreach (t[i]) begin
      issue(0, t[i].we, t[i].mode, t[i].addr, t[i].wdata, 1'b1, t[i].err, t[i].rdata, acc);
      collect(1, got);
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL errors[%0d]: no response, want one", i);
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o.k !== e.k || o.err !== e.err || o.rdata !== e.rdata || (o.cyc - e.acc) != lat_of(e.k)) begin
          tests_failed++;
          $display("FAIL errors[%0d]: got dut=%0d err=%0b rdata=%08h lat=%0d, want dut=%0d err=%0b rdata=%08h lat=%0d",
                   i, o.k, o.err, o.rdata, o.cyc - e.acc, e.k, e.err, e.rdata, lat_of(e.k));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    obs_t o;
    logic got;
    int   acc;
    issue(2, 1'b1, 3'b010, 32'h20, 32'h11111111, 1'b1, 1'b0, 32'h0, acc);
    collect(1, got);
    if (got) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
    end
    exp_q.delete();
    issue(2, 1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, acc);
    @(posedge clk);
    #2;
    tests_run++;
    if (s_busy[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_busy_before: busy=%0b, want 1", s_busy[2]);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (s_busy[2] !== 1'b0 || s_valid[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_in_reset: busy=%0b rsp_valid=%0b, want 0 0", s_busy[2], s_valid[2]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    tests_run++;
    if (obs_q.size() != 0 || r_ready[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_after: responses=%0d req_ready=%0b, want 0 1", obs_q.size(), r_ready[2]);
    end
    obs_q.delete();
    issue(2, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h11111111, acc);
    collect(1, got);
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL abort_readback: no response, want one");
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.err !== e.err || o.rdata !== e.rdata || (o.cyc - e.acc) != 4) begin
        tests_failed++;
        $display("FAIL abort_readback: got err=%0b rdata=%08h lat=%0d, want err=%0b rdata=%08h lat=4",
                 o.err, o.rdata, o.cyc - e.acc, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_half_merge();
    txn_t t [$];
    exp_t e;
    obs_t o;
    logic got;
    int   acc;
    t.push_back('{1'b1, 3'b010, 32'h20, 32'h11112222, 1'b0, 32'h0});
    t.push_back('{1'b1, 3'b001, 32'h22, 32'h5555ABCD, 1'b0, 32'h0});
    t.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'hABCD2222});
    t.push_back('{1'b0, 3'b101, 32'h22, 32'h0,        1'b0, 32'h0000ABCD});
    t.push_back('{1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 32'hFFFFABCD});
    t.push_back('{1'b0, 3'b000, 32'h21, 32'h0,        1'b0, 32'h00000022});
    t.push_back('{1'b0, 3'b000, 32'h23, 32'h0,        1'b0, 32'hFFFFFFAB});
    t.push_back('{1'b0, 3'b100, 32'h23, 32'h0,        1'b0, 32'h000000AB});
    foreach (t[i]) begin
      issue(2, t[i].we, t[i].mode, t[i].addr, t[i].wdata, 1'b1, t[i].err, t[i].rdata, acc);
      collect(1, got);
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL half_merge[%0d]: no response, want one", i);
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o.k !== e.k || o.err !== e.err || o.rdata !== e.rdata || (o.cyc - e.acc) != lat_of(e.k)) begin
          tests_failed++;
          $display("FAIL half_merge[%0d]: got dut=%0d err=%0b rdata=%08h lat=%0d, want dut=%0d err=%0b rdata=%08h lat=%0d",
                   i, o.k, o.err, o.rdata, o.cyc - e.acc, e.k, e.err, e.rdata, lat_of(e.k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_l1();
    test_byte_l3();
    test_back_to_back();
    test_errors();
    test_reset_abort();
    test_half_merge();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end
endmodule
